// File: rtl/led_pattern_pkg.sv
// ---------------------------------------------------------------------------
// led_pattern_pkg
//  Shared definitions for the LED pattern generator: the run-time mode
//  encoding and the bounce-direction type used by the scan and breathe
//  patterns.
// ---------------------------------------------------------------------------
package led_pattern_pkg;

    localparam int MODE_W = 2;

    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t MODE_GRAY    = 2'd0;
    localparam mode_t MODE_BINARY  = 2'd1;
    localparam mode_t MODE_SCAN    = 2'd2;
    localparam mode_t MODE_BREATHE = 2'd3;

    // Direction of a bouncing counter (scan position, breathe duty)
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/led_prescaler.sv
// ---------------------------------------------------------------------------
// led_prescaler
//  Free-running LOG2DELAY-bit prescaler that produces the pattern step tick.
//  Ports:
//   clk     in   system clock
//   resetn  in   synchronous active-low reset
//   hold    in   1 = freeze the counter and suppress the tick
//   clear   in   1 = force the counter to zero this edge, suppress the tick
//   tick    out  combinational, high in the cycle before the counter wraps
// ---------------------------------------------------------------------------
module led_prescaler #(
    parameter int LOG2DELAY = 21
) (
    input  logic clk,
    input  logic resetn,
    input  logic hold,
    input  logic clear,
    output logic tick
);

    logic [LOG2DELAY-1:0] presc_q;
    logic [LOG2DELAY-1:0] presc_d;

    // The tick fires on the all-ones count; a clear (mode change) wins over a
    // coincident tick so the new pattern always starts from a clean period.
    always_comb begin
        tick    = (&presc_q) & ~hold & ~clear;
        presc_d = presc_q;
        if (clear) begin
            presc_d = '0;
        end else if (!hold) begin
            presc_d = presc_q + 1'b1;
        end
    end

    // Counter register; natural wrap to zero happens on the tick edge
    always_ff @(posedge clk) begin
        if (!resetn) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// ---------------------------------------------------------------------------
// led_pattern_gen
//  Parametrised LED pattern generator with four run-time modes: Gray count,
//  binary count, bouncing one-hot scan and PWM breathe.
//  Ports:
//   clk     in   system clock
//   resetn  in   synchronous active-low reset
//   mode    in   0=GRAY 1=BINARY 2=SCAN 3=BREATHE
//   hold    in   1 = freeze prescaler and pattern state (PWM keeps running)
//   step    out  1-cycle pulse, high in the cycle a new pattern appears
//   leds    out  registered LED drive, 1 = on, leds[NUM_LEDS-1] is the MSB
// ---------------------------------------------------------------------------
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int NUM_LEDS  = 5,
    parameter int LOG2DELAY = 21,
    parameter int PWM_BITS  = 8
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [MODE_W-1:0]   mode,
    input  logic                hold,
    output logic                step,
    output logic [NUM_LEDS-1:0] leds
);

    localparam int                POS_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [POS_W-1:0]  POS_MAX  = POS_W'(NUM_LEDS - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

    logic                mode_change;
    logic                tick;

    mode_t               mode_q;
    logic [NUM_LEDS-1:0] cnt_q,  cnt_d;
    logic [POS_W-1:0]    pos_q,  pos_d;
    dir_e                dir_q,  dir_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    dir_e                duty_dir_q, duty_dir_d;
    logic [PWM_BITS-1:0] pwm_q,  pwm_d;
    logic                tick_q, tick_d;
    logic                step_q, step_d;
    logic [NUM_LEDS-1:0] leds_q, leds_d;
    logic [NUM_LEDS-1:0] scan_vec;

    assign mode_change = (mode != mode_q);

    led_prescaler #(
        .LOG2DELAY (LOG2DELAY)
    ) u_prescaler (
        .clk    (clk),
        .resetn (resetn),
        .hold   (hold),
        .clear  (mode_change),
        .tick   (tick)
    );

    // Pattern state update. A mode change restarts every pattern from its
    // initial state; otherwise all patterns advance together on each tick so
    // that the mode mux below only has to pick which one is shown.
    always_comb begin
        cnt_d      = cnt_q;
        pos_d      = pos_q;
        dir_d      = dir_q;
        duty_d     = duty_q;
        duty_dir_d = duty_dir_q;
        pwm_d      = pwm_q + 1'b1;

        if (mode_change) begin
            cnt_d      = '0;
            pos_d      = '0;
            dir_d      = DIR_UP;
            duty_d     = '0;
            duty_dir_d = DIR_UP;
        end else if (tick) begin
            cnt_d = cnt_q + 1'b1;

            // Bouncing scan: each end position is shown once per bounce
            if (NUM_LEDS == 1) begin
                pos_d = '0;
            end else if (dir_q == DIR_UP) begin
                if (pos_q == POS_MAX) begin
                    dir_d = DIR_DOWN;
                    pos_d = pos_q - 1'b1;
                end else begin
                    pos_d = pos_q + 1'b1;
                end
            end else begin
                if (pos_q == '0) begin
                    dir_d = DIR_UP;
                    pos_d = pos_q + 1'b1;
                end else begin
                    pos_d = pos_q - 1'b1;
                end
            end

            // Breathe duty follows the same triangle over 0..DUTY_MAX
            if (duty_dir_q == DIR_UP) begin
                if (duty_q == DUTY_MAX) begin
                    duty_dir_d = DIR_DOWN;
                    duty_d     = duty_q - 1'b1;
                end else begin
                    duty_d = duty_q + 1'b1;
                end
            end else begin
                if (duty_q == '0) begin
                    duty_dir_d = DIR_UP;
                    duty_d     = duty_q + 1'b1;
                end else begin
                    duty_d = duty_q - 1'b1;
                end
            end
        end
    end

    // Output mux from the current state. The tick is delayed twice so that
    // step rises in the same cycle as the registered LEDs show the new state.
    always_comb begin
        scan_vec = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            scan_vec[i] = (pos_q == POS_W'(i));
        end

        leds_d = '0;
        case (mode_q)
            MODE_GRAY:    leds_d = cnt_q ^ (cnt_q >> 1);
            MODE_BINARY:  leds_d = cnt_q;
            MODE_SCAN:    leds_d = scan_vec;
            MODE_BREATHE: leds_d = {NUM_LEDS{pwm_q < duty_q}};
            default:      leds_d = '0;
        endcase

        tick_d = tick;
        step_d = tick_q;
    end

    // State and output registers; mode is sampled even during reset so the
    // first cycle after reset does not look like a mode change.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mode_q     <= mode;
            cnt_q      <= '0;
            pos_q      <= '0;
            dir_q      <= DIR_UP;
            duty_q     <= '0;
            duty_dir_q <= DIR_UP;
            pwm_q      <= '0;
            tick_q     <= 1'b0;
            step_q     <= 1'b0;
            leds_q     <= '0;
        end else begin
            mode_q     <= mode;
            cnt_q      <= cnt_d;
            pos_q      <= pos_d;
            dir_q      <= dir_d;
            duty_q     <= duty_d;
            duty_dir_q <= duty_dir_d;
            pwm_q      <= pwm_d;
            tick_q     <= tick_d;
            step_q     <= step_d;
            leds_q     <= leds_d;
        end
    end

    assign step = step_q;
    assign leds = leds_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_led_pattern_gen
//  Directed bench for led_pattern_gen (NUM_LEDS=5, LOG2DELAY=2, PWM_BITS=3)
//  plus a NUM_LEDS=1 instance held in SCAN mode.
// ---------------------------------------------------------------------------
module tb_led_pattern_gen;
    import led_pattern_pkg::*;

    logic       clk = 1'b0;
    logic       resetn;
    logic       hold;
    logic [1:0] mode;
    logic [1:0] mode1;
    logic       step;
    logic       step1;
    logic [4:0] leds;
    logic [0:0] leds1;

    int nAsserts = 0;
    int nFails   = 0;

    logic [4:0] grayTab [8] = '{5'b00001, 5'b00011, 5'b00010, 5'b00110,
                                5'b00111, 5'b00101, 5'b00100, 5'b01100};
    logic [4:0] scanTab [9] = '{5'b00010, 5'b00100, 5'b01000, 5'b10000,
                                5'b01000, 5'b00100, 5'b00010, 5'b00001,
                                5'b00010};
    int         dutyTab [15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    logic [4:0] kv;
    logic [4:0] expLeds;
    int         ones;
    int         bad;

    always #5 clk = ~clk;

    led_pattern_gen #(
        .NUM_LEDS  (5),
        .LOG2DELAY (2),
        .PWM_BITS  (3)
    ) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .mode   (mode),
        .hold   (hold),
        .step   (step),
        .leds   (leds)
    );

    led_pattern_gen #(
        .NUM_LEDS  (1),
        .LOG2DELAY (2),
        .PWM_BITS  (3)
    ) u_dut1 (
        .clk    (clk),
        .resetn (resetn),
        .mode   (mode1),
        .hold   (hold),
        .step   (step1),
        .leds   (leds1)
    );

    // Advance n clock edges, sampling 1 time unit after each rising edge
    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic rn, input logic [1:0] m, input logic h);
        resetn = rn;
        mode   = m;
        hold   = h;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Run until step is seen, bounded by a cycle budget
    task automatic waitStep(input int budget);
        int n = 0;
        do begin
            cycle(1);
            n++;
        end while (step !== 1'b1 && n < budget);
        checkOutput("stepReached", {31'd0, step}, 32'd1);
    endtask

    // Global watchdog so the run always ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence
    initial begin
        // Reset in GRAY mode
        applyStimulus(1'b0, MODE_GRAY, 1'b0);
        mode1 = MODE_SCAN;
        cycle(2);
        checkOutput("resetLeds", {27'd0, leds}, 32'd0);
        checkOutput("resetStep", {31'd0, step}, 32'd0);
        resetn = 1'b1;
        cycle(1);
        checkOutput("grayP0", {27'd0, leds}, 32'd0);
        checkOutput("grayP0Step", {31'd0, step}, 32'd0);
        checkOutput("scan1Led", {31'd0, leds1}, 32'd1);
        cycle(3);
        checkOutput("grayPreStep", {31'd0, step}, 32'd0);

        // GRAY: first steps from the hand table
        for (int k = 1; k <= 8; k++) begin
            cycle(1);
            checkOutput("grayStep", {31'd0, step}, 32'd1);
            checkOutput("grayLeds", {27'd0, leds}, {27'd0, grayTab[k-1]});
            cycle(1);
            checkOutput("grayStepWidth", {31'd0, step}, 32'd0);
            cycle(2);
        end
        // GRAY: continue through the wrap at 32 steps
        for (int k = 9; k <= 33; k++) begin
            cycle(1);
            kv      = 5'(k);
            expLeds = kv ^ (kv >> 1);
            checkOutput("grayWrapStep", {31'd0, step}, 32'd1);
            checkOutput("grayWrapLeds", {27'd0, leds}, {27'd0, expLeds});
            cycle(3);
        end

        // BINARY
        cycle(1);
        mode = MODE_BINARY;
        cycle(1);
        cycle(1);
        checkOutput("binP0", {27'd0, leds}, 32'd0);
        checkOutput("binP0Step", {31'd0, step}, 32'd0);
        cycle(3);
        for (int k = 1; k <= 32; k++) begin
            cycle(1);
            checkOutput("binStep", {31'd0, step}, 32'd1);
            checkOutput("binLeds", {27'd0, leds}, 32'(k % 32));
            cycle(1);
            checkOutput("binStepWidth", {31'd0, step}, 32'd0);
            cycle(2);
        end

        // Hold in BINARY: frozen leds, no step, resume from held prescaler
        cycle(1);
        checkOutput("preHoldLeds", {27'd0, leds}, 32'd1);
        hold = 1'b1;
        for (int c = 0; c < 20; c++) begin
            cycle(1);
            checkOutput("holdStep", {31'd0, step}, 32'd0);
            checkOutput("holdLeds", {27'd0, leds}, 32'd1);
        end
        hold = 1'b0;
        cycle(3);
        checkOutput("resumeNoStep", {31'd0, step}, 32'd0);
        cycle(1);
        checkOutput("resumeStep", {31'd0, step}, 32'd1);
        checkOutput("resumeLeds", {27'd0, leds}, 32'd2);

        // SCAN
        mode = MODE_SCAN;
        cycle(1);
        cycle(1);
        checkOutput("scanP0", {27'd0, leds}, 32'd1);
        cycle(3);
        for (int k = 1; k <= 9; k++) begin
            cycle(1);
            checkOutput("scanStep", {31'd0, step}, 32'd1);
            checkOutput("scanLeds", {27'd0, leds}, {27'd0, scanTab[k-1]});
            checkOutput("scan1Led", {31'd0, leds1}, 32'd1);
            cycle(3);
        end

        // Back to GRAY, then switch to SCAN on a tick cycle
        cycle(1);
        mode = MODE_GRAY;
        cycle(1);
        cycle(1);
        checkOutput("gray2P0", {27'd0, leds}, 32'd0);
        cycle(3);
        cycle(1);
        checkOutput("gray2Step", {31'd0, step}, 32'd1);
        checkOutput("gray2Leds", {27'd0, leds}, 32'd1);
        cycle(2);
        mode = MODE_SCAN;
        cycle(1);
        checkOutput("switchEdgeStep", {31'd0, step}, 32'd0);
        cycle(1);
        checkOutput("switchNoStep", {31'd0, step}, 32'd0);
        checkOutput("switchScanP0", {27'd0, leds}, 32'd1);
        cycle(3);
        checkOutput("switchPreStep", {31'd0, step}, 32'd0);
        cycle(1);
        checkOutput("switchStep", {31'd0, step}, 32'd1);
        checkOutput("switchLeds", {27'd0, leds}, 32'd2);

        // Reset mid-run on a cycle where a tick was due
        cycle(2);
        resetn = 1'b0;
        cycle(1);
        checkOutput("midResetLeds", {27'd0, leds}, 32'd0);
        checkOutput("midResetStep", {31'd0, step}, 32'd0);
        checkOutput("midReset1Led", {31'd0, leds1}, 32'd0);
        resetn = 1'b1;
        cycle(1);
        checkOutput("postResetLeds", {27'd0, leds}, 32'd1);
        checkOutput("postResetStep", {31'd0, step}, 32'd0);
        checkOutput("postReset1Led", {31'd0, leds1}, 32'd1);
        cycle(3);
        checkOutput("postResetPre", {31'd0, step}, 32'd0);
        cycle(1);
        checkOutput("postResetStep1", {31'd0, step}, 32'd1);
        checkOutput("postResetLeds1", {27'd0, leds}, 32'd2);

        // BREATHE: duty 0 window, then the triangle
        mode = MODE_BREATHE;
        cycle(1);
        cycle(1);
        checkOutput("breatheP0", {27'd0, leds}, 32'd0);
        hold = 1'b1;
        ones = 0;
        for (int c = 0; c < 8; c++) begin
            cycle(1);
            if (leds !== 5'b00000) ones++;
        end
        hold = 1'b0;
        checkOutput("breatheDuty0", 32'(ones), 32'd0);
        for (int k = 1; k <= 15; k++) begin
            waitStep(16);
            hold = 1'b1;
            ones = 0;
            bad  = 0;
            for (int c = 0; c < 8; c++) begin
                cycle(1);
                if (leds[0]) ones++;
                if (leds !== 5'b00000 && leds !== 5'b11111) bad++;
            end
            hold = 1'b0;
            checkOutput("breatheOnCount", 32'(ones), 32'(dutyTab[k-1]));
            checkOutput("breatheUniform", 32'(bad), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
